// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared FSM state type, default widths and one-hot index helper for the L2 read arbiter.
package l2_arb_pkg;
    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) if (oh[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/l2_read_arbiter_rr_grant.sv
// rr_grant: combinational round-robin pick of the first set request at or after rr_ptr_i, cyclically.
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);
    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_i) + i;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            if (req_i[idx] && !found) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/l2_read_arbiter.sv
// l2_read_arbiter: round-robin sharing of the L2 line-read port, one outstanding transaction.
// Optional response watchdog enabled by defining L2_ARB_TIMEOUT_EN.
module l2_read_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = l2_arb_pkg::ADDR_W,
    parameter int LINE_W         = l2_arb_pkg::LINE_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  REQ_ADDR,
    input  logic [NUM_REQ-1:0]              REQ_ADDR_VALID,
    output logic [LINE_W-1:0]               RSP_DATA,
    output logic [NUM_REQ-1:0]              RSP_DATA_VALID,
    output logic [ADDR_W-1:0]               L2_S_R_ADDR,
    output logic                            L2_S_R_ADDR_VALID,
    input  logic [LINE_W-1:0]               L2_S_R_DATA,
    input  logic                            L2_S_R_DATA_VALID,
    output logic                            TIMEOUT_ERR
);
    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state_q;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, win_idx, grant_idx;
    logic [NUM_REQ-1:0] win, grant_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               strobe_q, timeout;

    rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
        .req_i   (REQ_ADDR_VALID),
        .rr_ptr_i(rr_ptr_q),
        .grant_o (win)
    );

    assign win_idx   = PTR_W'(onehot_to_idx(32'(win)));
    assign grant_idx = PTR_W'(onehot_to_idx(32'(grant_q)));
    assign rr_ptr_d  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Response is forwarded combinationally only while a transaction is in flight.
    assign RSP_DATA_VALID    = (state_q == WAIT && L2_S_R_DATA_VALID) ? grant_q : '0;
    assign RSP_DATA          = (|RSP_DATA_VALID) ? L2_S_R_DATA : '0;
    assign L2_S_R_ADDR       = addr_q;
    assign L2_S_R_ADDR_VALID = strobe_q;

`ifdef L2_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            err_q;

    assign timeout     = (state_q == WAIT) && !L2_S_R_DATA_VALID && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign TIMEOUT_ERR = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= (state_q == WAIT) ? wd_cnt_q + 1'b1 : '0;
            err_q    <= err_q | timeout;
        end
    end
`else
    assign timeout     = 1'b0;
    assign TIMEOUT_ERR = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: if (|REQ_ADDR_VALID) begin
                    state_q  <= ISSUE;
                    grant_q  <= win;
                    addr_q   <= REQ_ADDR[win_idx];
                    strobe_q <= 1'b1;
                end
                ISSUE: state_q <= WAIT;
                WAIT: if (L2_S_R_DATA_VALID) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= rr_ptr_d;
                end else if (timeout) begin
                    state_q  <= ISSUE;
                    strobe_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_read_arbiter.sv
// tb_l2_read_arbiter: table-driven transactions plus hand sequences; responses checked by a scoreboard.
module tb_l2_read_arbiter;
    logic              clk = 1'b0;
    logic              reset;
    logic [1:0][63:0]  REQ_ADDR;
    logic [1:0]        REQ_ADDR_VALID;
    logic [511:0]      RSP_DATA;
    logic [1:0]        RSP_DATA_VALID;
    logic [63:0]       L2_S_R_ADDR;
    logic              L2_S_R_ADDR_VALID;
    logic [511:0]      L2_S_R_DATA;
    logic              L2_S_R_DATA_VALID;
    logic              TIMEOUT_ERR;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]   g;
        logic [511:0] d;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]   v;
        logic [63:0]  a0;
        logic [63:0]  a1;
        int           lat;
        logic [511:0] d;
        logic [1:0]   eg;
        logic [63:0]  ea;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    l2_read_arbiter #(.NUM_REQ(2), .ADDR_W(64), .LINE_W(512), .TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .REQ_ADDR         (REQ_ADDR),
        .REQ_ADDR_VALID   (REQ_ADDR_VALID),
        .RSP_DATA         (RSP_DATA),
        .RSP_DATA_VALID   (RSP_DATA_VALID),
        .L2_S_R_ADDR      (L2_S_R_ADDR),
        .L2_S_R_ADDR_VALID(L2_S_R_ADDR_VALID),
        .L2_S_R_DATA      (L2_S_R_DATA),
        .L2_S_R_DATA_VALID(L2_S_R_DATA_VALID),
        .TIMEOUT_ERR      (TIMEOUT_ERR)
    );

    task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && RSP_DATA_VALID != 2'b00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp got=%b exp=none", RSP_DATA_VALID);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", RSP_DATA_VALID, e.g);
                chk("rsp_data", RSP_DATA, e.d);
            end
        end
    end

    task automatic run_txn(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1, input int lat,
                           input logic [511:0] d, input logic [1:0] eg, input logic [63:0] ea, input bit drop);
        REQ_ADDR_VALID = v;
        REQ_ADDR[0]    = a0;
        REQ_ADDR[1]    = a1;
        sb.push_back('{g: eg, d: d});
        tick();
        chk("strobe", L2_S_R_ADDR_VALID, 1'b1);
        chk("l2_addr", L2_S_R_ADDR, ea);
        tick();
        chk("strobe_1cyc", L2_S_R_ADDR_VALID, 1'b0);
        repeat (lat) tick();
        L2_S_R_DATA       = d;
        L2_S_R_DATA_VALID = 1'b1;
        tick();
        L2_S_R_DATA       = '0;
        L2_S_R_DATA_VALID = 1'b0;
        if (drop) REQ_ADDR_VALID = REQ_ADDR_VALID & ~eg;
    endtask

    initial begin
        vecs[0] = '{2'b01, 64'h1000, 64'h0,    3, {64{8'hAB}},          2'b01, 64'h1000};
        vecs[1] = '{2'b11, 64'h1000, 64'h2000, 0, {16{32'h1111_0001}}, 2'b10, 64'h2000};
        vecs[2] = '{2'b11, 64'h3000, 64'h4000, 1, {16{32'h2222_0002}}, 2'b01, 64'h3000};
        vecs[3] = '{2'b10, 64'h0,    64'h5000, 2, {16{32'h3333_0003}}, 2'b10, 64'h5000};
        vecs[4] = '{2'b10, 64'h0,    64'h6000, 0, {16{32'h4444_0004}}, 2'b10, 64'h6000};
        vecs[5] = '{2'b01, 64'h7000, 64'h0,    1, {16{32'h5555_0005}}, 2'b01, 64'h7000};
        vecs[6] = '{2'b01, 64'h8000, 64'h0,    2, {16{32'h6666_0006}}, 2'b01, 64'h8000};
        vecs[7] = '{2'b11, 64'h9000, 64'hA000, 3, {16{32'h7777_0007}}, 2'b10, 64'hA000};

        reset             = 1'b1;
        REQ_ADDR          = '0;
        REQ_ADDR_VALID    = '0;
        L2_S_R_DATA       = '0;
        L2_S_R_DATA_VALID = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_strobe", L2_S_R_ADDR_VALID, 1'b0);
        chk("rst_addr", L2_S_R_ADDR, 64'h0);
        chk("rst_rsp_valid", RSP_DATA_VALID, 2'b00);
        chk("rst_rsp_data", RSP_DATA, 512'h0);
        chk("rst_err", TIMEOUT_ERR, 1'b0);

        foreach (vecs[i]) run_txn(vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].lat, vecs[i].d, vecs[i].eg, vecs[i].ea, 1'b1);
        REQ_ADDR_VALID = '0;
        tick();
        chk("idle_no_strobe", L2_S_R_ADDR_VALID, 1'b0);

        // Both held after reset: alternating grants starting at req 0, then rr_ptr back at 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++)
            run_txn(2'b11, 64'h1000, 64'h2000, k % 3, {16{32'hFA00_0000 | 32'(k)}},
                    (k % 2) ? 2'b10 : 2'b01, (k % 2) ? 64'h2000 : 64'h1000, 1'b0);
        run_txn(2'b11, 64'h1000, 64'h2000, 1, {16{32'hFA00_0010}}, 2'b01, 64'h1000, 1'b1);
        REQ_ADDR_VALID = '0;
        tick();

        // Spurious L2 data in IDLE and ISSUE; requester also drops VALID while granted.
        L2_S_R_DATA       = {64{8'h5A}};
        L2_S_R_DATA_VALID = 1'b1;
        chk("spur_idle_rsp", RSP_DATA_VALID, 2'b00);
        chk("spur_idle_data", RSP_DATA, 512'h0);
        tick();
        chk("spur_idle_strobe", L2_S_R_ADDR_VALID, 1'b0);
        REQ_ADDR_VALID = 2'b01;
        REQ_ADDR[0]    = 64'hC000;
        tick();
        chk("spur_issue_rsp", RSP_DATA_VALID, 2'b00);
        chk("spur_issue_strobe", L2_S_R_ADDR_VALID, 1'b1);
        chk("spur_issue_addr", L2_S_R_ADDR, 64'hC000);
        L2_S_R_DATA_VALID = 1'b0;
        REQ_ADDR_VALID    = 2'b00;
        tick();
        chk("drop_wait_rsp", RSP_DATA_VALID, 2'b00);
        chk("drop_wait_data", RSP_DATA, 512'h0);
        chk("drop_wait_addr", L2_S_R_ADDR, 64'hC000);
        sb.push_back('{g: 2'b01, d: {16{32'hC0C0_C0C0}}});
        L2_S_R_DATA       = {16{32'hC0C0_C0C0}};
        L2_S_R_DATA_VALID = 1'b1;
        tick();
        L2_S_R_DATA       = '0;
        L2_S_R_DATA_VALID = 1'b0;
        tick();
        chk("drop_idle_strobe", L2_S_R_ADDR_VALID, 1'b0);

        // Reset while waiting: grant discarded, held request re-issued after release.
        REQ_ADDR_VALID = 2'b10;
        REQ_ADDR[1]    = 64'hD000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_strobe", L2_S_R_ADDR_VALID, 1'b0);
        chk("rstw_addr", L2_S_R_ADDR, 64'h0);
        chk("rstw_rsp", RSP_DATA_VALID, 2'b00);
        tick();
        chk("rstw_reissue", L2_S_R_ADDR_VALID, 1'b1);
        chk("rstw_reissue_addr", L2_S_R_ADDR, 64'hD000);
        tick();
        sb.push_back('{g: 2'b10, d: {16{32'hD0D0_0001}}});
        L2_S_R_DATA       = {16{32'hD0D0_0001}};
        L2_S_R_DATA_VALID = 1'b1;
        tick();
        L2_S_R_DATA       = '0;
        L2_S_R_DATA_VALID = 1'b0;
        REQ_ADDR_VALID    = 2'b00;
        tick();

        // Long L2 silence: watchdog re-strobe when enabled, otherwise an indefinite wait.
        REQ_ADDR_VALID = 2'b01;
        REQ_ADDR[0]    = 64'hE000;
        tick();
        chk("wd_strobe", L2_S_R_ADDR_VALID, 1'b1);
        tick();
`ifdef L2_ARB_TIMEOUT_EN
        repeat (7) tick();
        chk("wd_err_before", TIMEOUT_ERR, 1'b0);
        chk("wd_strobe_before", L2_S_R_ADDR_VALID, 1'b0);
        tick();
        chk("wd_err_set", TIMEOUT_ERR, 1'b1);
        chk("wd_restrobe", L2_S_R_ADDR_VALID, 1'b1);
        chk("wd_restrobe_addr", L2_S_R_ADDR, 64'hE000);
        tick();
        chk("wd_restrobe_1cyc", L2_S_R_ADDR_VALID, 1'b0);
        tick();
`else
        repeat (20) tick();
        chk("nowd_strobe", L2_S_R_ADDR_VALID, 1'b0);
        chk("nowd_err", TIMEOUT_ERR, 1'b0);
`endif
        sb.push_back('{g: 2'b01, d: {16{32'hE0E0_0001}}});
        L2_S_R_DATA       = {16{32'hE0E0_0001}};
        L2_S_R_DATA_VALID = 1'b1;
        tick();
        L2_S_R_DATA       = '0;
        L2_S_R_DATA_VALID = 1'b0;
        REQ_ADDR_VALID    = 2'b00;
        tick();
`ifdef L2_ARB_TIMEOUT_EN
        chk("wd_err_sticky", TIMEOUT_ERR, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wd_err_cleared", TIMEOUT_ERR, 1'b0);
`endif
        tick();
        chk("sb_drained", 512'(sb.size()), 512'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
